// File: rtl/bus_source_if.sv
// Single-word data bus carrying one DW-bit value from a source to a sink.
interface bus #(
  parameter int DW = 8
) ();
  logic [DW-1:0] dat;

  modport o (output dat);
  modport i (input dat);
endinterface

// File: rtl/bus_source.sv
// Burst generator: on start, drives LEN words INIT, INIT+STEP, ... onto the bus,
// with hold/stop control and a one-cycle done pulse at the end of each burst.
module bus_source #(
  parameter int LEN  = 16,
  parameter int INIT = 0,
  parameter int STEP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       hold,
  input  logic                       stop,
  bus.o                              o,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(LEN+1)-1:0]   cnt
);

  localparam int DW = o.DW;
  localparam int CW = $clog2(LEN + 1);

  localparam logic [DW-1:0] INIT_W = DW'(INIT);
  localparam logic [DW-1:0] STEP_W = DW'(STEP);
  localparam logic [CW-1:0] LEN_W  = CW'(LEN);
  localparam logic [CW-1:0] ONE_W  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dat_q,   dat_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // stop beats a simultaneous start: nothing happens this cycle
        if (start && !stop) begin
          state_d = RUN;
          dat_d   = INIT_W;
          cnt_d   = ONE_W;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!hold) begin
          if (cnt_q < LEN_W) begin
            dat_d = dat_q + STEP_W;
            cnt_d = cnt_q + ONE_W;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dat_q   <= INIT_W;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o.dat = dat_q;
  assign cnt   = cnt_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_bus_source.sv
// Bench for bus_source: five differently parameterised instances share one set of
// control inputs and are compared against a word-index model of the burst rules.
module tb_bus_source;

  localparam int NI = 5;

  logic clk;
  logic rst;
  logic start;
  logic hold;
  logic stop;

  int n_checks;
  int n_fail;

  // instance parameters: A basic, B wrap, C hold/stop, D LEN=1, E truncated STEP
  int m_len  [NI] = '{4, 4, 4, 1, 5};
  int m_init [NI] = '{3, 14, 0, 90, 6};
  int m_step [NI] = '{2, 1, 1, 3, 11};
  int m_dw   [NI] = '{4, 4, 4, 8, 3};

  // model: mode 0 idle, 1 emitting, 2 done cycle; m_n words emitted
  int m_mode [NI];
  int m_n    [NI];

  bus #(.DW(4)) bus_a ();
  bus #(.DW(4)) bus_b ();
  bus #(.DW(4)) bus_c ();
  bus #(.DW(8)) bus_d ();
  bus #(.DW(3)) bus_e ();

  logic [2:0] cnt_a, cnt_b, cnt_c, cnt_e;
  logic [0:0] cnt_d;
  logic       busy_o [NI];
  logic       done_o [NI];
  logic [7:0] dat_o  [NI];
  logic [7:0] cnt_o  [NI];

  bus_source #(.LEN(4), .INIT(3), .STEP(2)) u_a (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .stop(stop),
    .o(bus_a), .busy(busy_o[0]), .done(done_o[0]), .cnt(cnt_a));
  bus_source #(.LEN(4), .INIT(14), .STEP(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .stop(stop),
    .o(bus_b), .busy(busy_o[1]), .done(done_o[1]), .cnt(cnt_b));
  bus_source #(.LEN(4), .INIT(0), .STEP(1)) u_c (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .stop(stop),
    .o(bus_c), .busy(busy_o[2]), .done(done_o[2]), .cnt(cnt_c));
  bus_source #(.LEN(1), .INIT(90), .STEP(3)) u_d (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .stop(stop),
    .o(bus_d), .busy(busy_o[3]), .done(done_o[3]), .cnt(cnt_d));
  bus_source #(.LEN(5), .INIT(6), .STEP(11)) u_e (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .stop(stop),
    .o(bus_e), .busy(busy_o[4]), .done(done_o[4]), .cnt(cnt_e));

  assign dat_o[0] = 8'(bus_a.dat);
  assign dat_o[1] = 8'(bus_b.dat);
  assign dat_o[2] = 8'(bus_c.dat);
  assign dat_o[3] = 8'(bus_d.dat);
  assign dat_o[4] = 8'(bus_e.dat);
  assign cnt_o[0] = 8'(cnt_a);
  assign cnt_o[1] = 8'(cnt_b);
  assign cnt_o[2] = 8'(cnt_c);
  assign cnt_o[3] = 8'(cnt_d);
  assign cnt_o[4] = 8'(cnt_e);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = 0;
      m_n[i]    = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      case (m_mode[i])
        0: if (start && !stop) begin m_mode[i] = 1; m_n[i] = 1; end
        1: begin
          if (stop) m_mode[i] = 0;
          else if (!hold) begin
            if (m_n[i] < m_len[i]) m_n[i] = m_n[i] + 1;
            else m_mode[i] = 2;
          end
        end
        default: m_mode[i] = 0;
      endcase
    end
  endtask

  // word k of a burst is INIT + k*STEP reduced to DW bits; idle after reset shows INIT
  function automatic int exp_dat(int i);
    int mask = (1 << m_dw[i]) - 1;
    if (m_n[i] == 0) return m_init[i] & mask;
    return (m_init[i] + (m_n[i] - 1) * m_step[i]) & mask;
  endfunction

  // one clock: inputs are stable across the posedge, outputs sampled at the negedge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic settle();
    start = 1'b0; hold = 1'b0; stop = 1'b0;
    repeat (8) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    model_reset();
    repeat (2) cyc();
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (dat_o[i] !== 8'(m_init[i] & ((1 << m_dw[i]) - 1)) || cnt_o[i] !== 8'd0 ||
          busy_o[i] !== 1'b0 || done_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset inst%0d: dat=%0d cnt=%0d busy=%b done=%b, required dat=%0d cnt=0 busy=0 done=0",
                 i, dat_o[i], cnt_o[i], busy_o[i], done_o[i], m_init[i] & ((1 << m_dw[i]) - 1));
      end
    end
    rst = 1'b0;
    cyc();
    start = 1'b0;
    n_checks++;
    if (busy_o[0] !== 1'b1 || dat_o[0] !== 8'd3 || cnt_o[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL start_after_release: busy=%b dat=%0d cnt=%0d, required 1 3 1", busy_o[0], dat_o[0], cnt_o[0]);
    end
    settle();
  endtask

  task automatic test_basic();
    int seq_a [4] = '{3, 5, 7, 9};
    int seq_b [4] = '{14, 15, 0, 1};
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      start = 1'b0;
      n_checks++;
      if (dat_o[0] !== 8'(seq_a[k]) || busy_o[0] !== 1'b1 || cnt_o[0] !== 8'(k + 1) || done_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL basic word%0d: dat=%0d busy=%b cnt=%0d done=%b, required dat=%0d busy=1 cnt=%0d done=0",
                 k, dat_o[0], busy_o[0], cnt_o[0], done_o[0], seq_a[k], k + 1);
      end
      n_checks++;
      if (dat_o[1] !== 8'(seq_b[k])) begin
        n_fail++;
        $display("FAIL wrap word%0d: dat=%0d, required %0d", k, dat_o[1], seq_b[k]);
      end
    end
    cyc();
    n_checks++;
    if (done_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || cnt_o[0] !== 8'd4 || dat_o[0] !== 8'd9) begin
      n_fail++;
      $display("FAIL basic done: done=%b busy=%b cnt=%0d dat=%0d, required 1 0 4 9",
               done_o[0], busy_o[0], cnt_o[0], dat_o[0]);
    end
    n_checks++;
    if (done_o[1] !== 1'b1 || dat_o[1] !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap done: done=%b dat=%0d, required 1 1", done_o[1], dat_o[1]);
    end
    cyc();
    n_checks++;
    if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || dat_o[0] !== 8'd9 || cnt_o[0] !== 8'd4) begin
      n_fail++;
      $display("FAIL basic idle: done=%b busy=%b dat=%0d cnt=%0d, required 0 0 9 4",
               done_o[0], busy_o[0], dat_o[0], cnt_o[0]);
    end
    settle();
  endtask

  task automatic test_hold();
    int seq [6]      = '{0, 1, 1, 1, 2, 3};
    int hold_pat [6] = '{0, 0, 1, 1, 0, 0};
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      hold = hold_pat[k][0];
      cyc();
      start = 1'b0;
      n_checks++;
      if (dat_o[2] !== 8'(seq[k]) || busy_o[2] !== 1'b1 || done_o[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold step%0d: dat=%0d busy=%b done=%b, required dat=%0d busy=1 done=0",
                 k, dat_o[2], busy_o[2], done_o[2], seq[k]);
      end
    end
    hold = 1'b0;
    cyc();
    n_checks++;
    if (done_o[2] !== 1'b1 || cnt_o[2] !== 8'd4 || dat_o[2] !== 8'd3) begin
      n_fail++;
      $display("FAIL hold done: done=%b cnt=%0d dat=%0d, required 1 4 3", done_o[2], cnt_o[2], dat_o[2]);
    end
    settle();
  endtask

  task automatic test_stop();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_checks++;
    if (busy_o[2] !== 1'b0 || done_o[2] !== 1'b0 || dat_o[2] !== 8'd1 || cnt_o[2] !== 8'd2) begin
      n_fail++;
      $display("FAIL stop: busy=%b done=%b dat=%0d cnt=%0d, required 0 0 1 2",
               busy_o[2], done_o[2], dat_o[2], cnt_o[2]);
    end
    cyc();
    n_checks++;
    if (done_o[2] !== 1'b0 || busy_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_no_done: done=%b busy=%b, required 0 0", done_o[2], busy_o[2]);
    end
    start = 1'b1; stop = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    n_checks++;
    if (busy_o[2] !== 1'b0 || dat_o[2] !== 8'd1 || cnt_o[2] !== 8'd2) begin
      n_fail++;
      $display("FAIL start_stop_idle: busy=%b dat=%0d cnt=%0d, required 0 1 2", busy_o[2], dat_o[2], cnt_o[2]);
    end
    // start kept high through the whole burst must not restart it
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++;
      if (dat_o[2] !== 8'(k) || cnt_o[2] !== 8'(k + 1) || busy_o[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL start_in_run word%0d: dat=%0d cnt=%0d busy=%b, required %0d %0d 1",
                 k, dat_o[2], cnt_o[2], busy_o[2], k, k + 1);
      end
    end
    start = 1'b0;
    cyc();
    n_checks++;
    if (done_o[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_run done: done=%b, required 1", done_o[2]);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    n_checks++;
    if (cnt_o[2] !== 8'd3) begin
      n_fail++;
      $display("FAIL reset_mid precondition: cnt=%0d, required 3", cnt_o[2]);
    end
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (dat_o[2] !== 8'd0 || cnt_o[2] !== 8'd0 || busy_o[2] !== 1'b0 || dat_o[0] !== 8'd3 || cnt_o[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid async: c.dat=%0d c.cnt=%0d c.busy=%b a.dat=%0d a.cnt=%0d, required 0 0 0 3 0",
               dat_o[2], cnt_o[2], busy_o[2], dat_o[0], cnt_o[0]);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done_o[2] !== 1'b0 || busy_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid no_done: done=%b busy=%b, required 0 0", done_o[2], busy_o[2]);
    end
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      start = 1'b0;
      n_checks++;
      if (dat_o[2] !== 8'(k) || cnt_o[2] !== 8'(k + 1) || dat_o[0] !== 8'(3 + 2 * k)) begin
        n_fail++;
        $display("FAIL reset_mid fresh word%0d: c.dat=%0d c.cnt=%0d a.dat=%0d, required %0d %0d %0d",
                 k, dat_o[2], cnt_o[2], dat_o[0], k, k + 1, 3 + 2 * k);
      end
    end
    settle();
  endtask

  task automatic test_len1();
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_checks++;
    if (busy_o[3] !== 1'b1 || dat_o[3] !== 8'd90 || cnt_o[3] !== 8'd1 || done_o[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL len1 run: busy=%b dat=%0d cnt=%0d done=%b, required 1 90 1 0",
               busy_o[3], dat_o[3], cnt_o[3], done_o[3]);
    end
    // start during the done cycle must be ignored
    start = 1'b1;
    cyc();
    n_checks++;
    if (busy_o[3] !== 1'b0 || done_o[3] !== 1'b1 || cnt_o[3] !== 8'd1) begin
      n_fail++;
      $display("FAIL len1 done: busy=%b done=%b cnt=%0d, required 0 1 1", busy_o[3], done_o[3], cnt_o[3]);
    end
    cyc();
    start = 1'b0;
    n_checks++;
    if (busy_o[3] !== 1'b0 || done_o[3] !== 1'b0 || dat_o[3] !== 8'd90) begin
      n_fail++;
      $display("FAIL len1 idle: busy=%b done=%b dat=%0d, required 0 0 90", busy_o[3], done_o[3], dat_o[3]);
    end
    settle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(39) == 0) begin
        #1 rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
      end
      start = ($urandom_range(2) == 0);
      hold  = ($urandom_range(3) == 0);
      stop  = ($urandom_range(7) == 0);
      cyc();
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (dat_o[i] !== 8'(exp_dat(i)) || cnt_o[i] !== 8'(m_n[i]) ||
            busy_o[i] !== (m_mode[i] == 1) || done_o[i] !== (m_mode[i] == 2)) begin
          n_fail++;
          $display("FAIL random c%0d inst%0d: dat=%0d cnt=%0d busy=%b done=%b, required dat=%0d cnt=%0d busy=%b done=%b",
                   c, i, dat_o[i], cnt_o[i], busy_o[i], done_o[i],
                   exp_dat(i), m_n[i], (m_mode[i] == 1), (m_mode[i] == 2));
        end
      end
    end
    settle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; hold = 1'b0; stop = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_hold();
    test_stop();
    test_reset_mid();
    test_len1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_source.md
BUS_SOURCE -- requirements
Module: bus_source

Interface
REQ-001 SHALL have parameter LEN, default 16, number of data words per burst; legal range LEN >= 1.
REQ-002 SHALL have parameter INIT, default 0, first data word of every burst.
REQ-003 SHALL have parameter STEP, default 1, increment between successive words; truncated to DW bits.
REQ-004 SHALL derive data width DW from the connected interface parameter (o.DW), not from a module parameter.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  request a burst; sampled in IDLE only.
REQ-008 SHALL have port hold  input  1  freeze burst progress while high.
REQ-009 SHALL have port stop  input  1  abort a running burst.
REQ-010 SHALL have port o  bus.o modport  DW  drives o.dat, the bus data word.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse on burst completion.
REQ-013 SHALL have port cnt  output  $clog2(LEN+1)  number of words emitted in the current or last burst.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE, all registered.
REQ-015 SHALL, in IDLE with start=1 and stop=0 at a posedge, load o.dat<=INIT and cnt<=1, then enter RUN; first word visible the cycle after start.
REQ-016 SHALL, in RUN with cnt<LEN, hold=0 and stop=0, update o.dat<=o.dat+STEP (mod 2^DW, carry discarded) and cnt<=cnt+1 each cycle.
REQ-017 SHALL, in RUN with cnt==LEN, hold=0 and stop=0, enter DONE with o.dat and cnt unchanged; burst emits exactly LEN words, INIT..INIT+(LEN-1)*STEP mod 2^DW.
REQ-018 SHALL, in RUN with hold=1 and stop=0, leave o.dat, cnt and state unchanged.
REQ-019 SHALL, in RUN with stop=1 (priority over hold and completion), enter IDLE with o.dat and cnt held and done not asserted.
REQ-020 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE unconditionally; start during DONE is ignored.
REQ-021 SHALL ignore start while in RUN or DONE; no restart and no counter reload.
REQ-022 SHALL, for start=1 and stop=1 in the same IDLE cycle, give stop priority: remain in IDLE with no state change.
REQ-023 SHALL, for LEN=1, emit one word: RUN for one cycle (cnt=1), then DONE.
REQ-024 SHALL keep o.dat in IDLE at the last driven value (INIT after reset) until the next start.
REQ-025 SHALL drive busy combinationally from state (busy = state==RUN); done = state==DONE.

Reset
REQ-026 SHALL, while rst=1, force asynchronously: state=IDLE, o.dat=INIT, cnt=0, busy=0, done=0.
REQ-027 SHALL, on rst asserted mid-burst, abandon the burst immediately with no done pulse; the first start after rst release begins a fresh burst from INIT.
REQ-028 SHALL ignore start while rst=1 and act on the first posedge after release.

Verification
REQ-029 SHALL cover basic burst: DW=4, LEN=4, INIT=3, STEP=2, start pulse -> o.dat 3,5,7,9 on consecutive cycles; busy high 4 cycles; then done=1 one cycle; cnt=4.
REQ-030 SHALL cover wrap-around: DW=4, INIT=14, STEP=1, LEN=4 -> o.dat 14,15,0,1; no extra bits set.
REQ-031 SHALL cover hold: LEN=4, INIT=0, STEP=1, hold=1 for 2 cycles after word 1 -> sequence 0,1,1,1,2,3; done after the 4th distinct word; cnt=4.
REQ-032 SHALL cover stop and simultaneity: stop at cnt=2 -> IDLE, o.dat=1, cnt=2, no done; start+stop together in IDLE -> no burst; start during RUN -> sequence unaffected.
REQ-033 SHALL cover reset mid-burst: rst pulse at cnt=3 between clock edges -> o.dat=INIT, cnt=0, busy=0 immediately; next start -> full burst from INIT.
REQ-034 SHALL cover LEN=1: start -> single word INIT, busy one cycle, done one cycle, back to IDLE.
